// File: rtl/simplez_pkg.sv
// Shared constants for the Simplez TX port: bus addresses, status bit positions
// and the transmitter state encoding.
package simplez_pkg;

  localparam logic [8:0] STATUS_ADDR = 9'd510;
  localparam logic [8:0] DATA_ADDR   = 9'd511;

  localparam int READY   = 0;
  localparam int OVERRUN = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/simplez_baud_tick.sv
// Bit-period timer: counts 0..BAUD_DIV-1 while enabled and flags the last
// cycle of each bit period with bit_end.
module simplez_baud_tick #(
  parameter int BAUD_DIV = 104
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic restart,
  output logic bit_end
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  // bit_end is decoded from the pre-edge count so the FSM acts on the wrap edge.
  assign bit_end = en && (cnt == LAST);

  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/simplez_tx_port.sv
// Memory-mapped 8N1 serial output for the Simplez bus: status/data registers
// plus a start/data/stop transmitter, all clocked on the falling edge.
module simplez_tx_port #(
  parameter logic [8:0] STATUS_ADDR = simplez_pkg::STATUS_ADDR,
  parameter logic [8:0] DATA_ADDR   = simplez_pkg::DATA_ADDR,
  parameter int         BAUD_DIV    = 104
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [8:0]  address,
  input  logic [11:0] data_in,
  input  logic        read_enable,
  input  logic        write_enable,
  output logic [11:0] data_out,
  output logic        sel,
  output logic        tx
);

  import simplez_pkg::*;

  tx_state_t   state;
  logic        ready;
  logic        overrun;
  logic [7:0]  last_char;
  logic [7:0]  shreg;
  logic [2:0]  bit_cnt;
  logic [11:0] status_word;

  logic bit_end;
  logic frame_done;
  logic wr_data;
  logic can_accept;
  logic accept;
  logic drop;
  logic status_rd;

  logic unused_data_hi;
  assign unused_data_hi = ^data_in[11:8];

  assign sel        = (address == STATUS_ADDR) || (address == DATA_ADDR);
  assign wr_data    = write_enable && (address == DATA_ADDR);
  assign status_rd  = read_enable && (address == STATUS_ADDR);
  assign frame_done = (state == STOP) && bit_end;
  // A frame ending on this edge frees the transmitter, so a write landing on
  // the same edge is taken back-to-back instead of counting as an overrun.
  assign can_accept = ready || frame_done;
  assign accept     = wr_data && can_accept;
  assign drop       = wr_data && !can_accept;

  always_comb begin
    status_word          = '0;
    status_word[READY]   = ready;
    status_word[OVERRUN] = overrun;
  end

  simplez_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk     (clk),
    .rstn    (rstn),
    .en      (state != IDLE),
    .restart (accept),
    .bit_end (bit_end)
  );

  // NOTE: non-blocking assignments make every read on an edge see the
  // pre-edge ready/overrun/last_char, even when a write hits the same edge.
  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      data_out <= '0;
    end else if (read_enable) begin
      if (address == STATUS_ADDR)    data_out <= status_word;
      else if (address == DATA_ADDR) data_out <= {4'b0, last_char};
      else                           data_out <= '0;
    end
  end

  // A dropped write sets overrun even if a status read clears it on that edge.
  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn)          overrun <= 1'b0;
    else if (drop)      overrun <= 1'b1;
    else if (status_rd) overrun <= 1'b0;
  end

  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      ready     <= 1'b1;
      last_char <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      tx        <= 1'b1;
    end else if (accept) begin
      last_char <= data_in[7:0];
      shreg     <= data_in[7:0];
      state     <= START;
      tx        <= 1'b0;
      ready     <= 1'b0;
      bit_cnt   <= '0;
    end else if (bit_end) begin
      case (state)
        START: begin
          state   <= DATA;
          tx      <= shreg[0];
          bit_cnt <= '0;
        end
        DATA: begin
          shreg <= shreg >> 1;
          if (bit_cnt == 3'd7) begin
            state <= STOP;
            tx    <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            tx      <= shreg[1];
          end
        end
        STOP: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simplez_tx_port.sv
// Directed bench for simplez_tx_port with BAUD_DIV=4: inputs change and outputs
// are sampled just after the rising edge, half a cycle away from the active edge.
module tb_simplez_tx_port;

  localparam int B = 4;

  logic        clk;
  logic        rstn;
  logic [8:0]  address;
  logic [11:0] data_in;
  logic        read_enable;
  logic        write_enable;
  logic [11:0] data_out;
  logic        sel;
  logic        tx;

  int n_checks = 0;
  int n_fail   = 0;

  simplez_tx_port #(
    .STATUS_ADDR (9'd510),
    .DATA_ADDR   (9'd511),
    .BAUD_DIV    (B)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .address      (address),
    .data_in      (data_in),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .data_out     (data_out),
    .sel          (sel),
    .tx           (tx)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One falling (active) edge passes inside each step.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line level k edges after the accept edge for an 8N1 frame.
  function automatic logic exp_tx(input logic [7:0] ch, input int k);
    int bitn;
    bitn = k / B;
    if (bitn == 0) return 1'b0;
    if (bitn <= 8) return ch[bitn-1];
    return 1'b1;
  endfunction

  task automatic bus_idle();
    read_enable  = 1'b0;
    write_enable = 1'b0;
  endtask

  task automatic rd(input logic [8:0] a, input logic [11:0] exp, input string tag);
    address     = a;
    read_enable = 1'b1;
    step();
    read_enable = 1'b0;
    check(tag, data_out, exp);
  endtask

  task automatic wr(input logic [8:0] a, input logic [11:0] d);
    address      = a;
    data_in      = d;
    write_enable = 1'b1;
    step();
    write_enable = 1'b0;
  endtask

  task automatic watch_tx(input logic [7:0] ch, input int k0, input int k1, input string tag);
    for (int k = k0; k <= k1; k++) begin
      step();
      check($sformatf("%s k=%0d", tag, k), {11'b0, tx}, {11'b0, exp_tx(ch, k)});
    end
  endtask

  initial begin
    rstn    = 1'b1;
    address = '0;
    data_in = '0;
    bus_idle();
    #2 rstn = 1'b0;
    #1;
    check("reset tx", {11'b0, tx}, 12'h001);
    check("reset data_out", data_out, 12'h000);
    step();
    step();
    rstn = 1'b1;
    step();

    rd(9'd510, 12'h001, "status after reset");
    check("idle tx", {11'b0, tx}, 12'h001);

    // Frame of 0xA5 with an overrunning write and reads interleaved.
    wr(9'd511, 12'h0A5);
    check("f1 k=0", {11'b0, tx}, 12'h000);
    for (int k = 1; k <= 41; k++) begin
      bus_idle();
      case (k)
        8: begin
          address      = 9'd511;
          data_in      = 12'h041;
          write_enable = 1'b1;
        end
        10, 12, 20, 40, 41: begin
          address     = 9'd510;
          read_enable = 1'b1;
        end
        14: begin
          address     = 9'd511;
          read_enable = 1'b1;
        end
        default: ;
      endcase
      step();
      check($sformatf("f1 tx k=%0d", k), {11'b0, tx}, {11'b0, exp_tx(8'hA5, k)});
      case (k)
        10: check("status overrun", data_out, 12'h002);
        12: check("overrun cleared", data_out, 12'h000);
        14: check("last_char A5", data_out, 12'h0A5);
        20: check("status busy", data_out, 12'h000);
        40: check("status on ready edge", data_out, 12'h000);
        41: check("status ready again", data_out, 12'h001);
        default: ;
      endcase
    end
    bus_idle();

    // Back-to-back: second write lands on the edge the first frame ends.
    wr(9'd511, 12'h0F0);
    check("f2 k=0", {11'b0, tx}, 12'h000);
    watch_tx(8'hF0, 1, 39, "f2 tx");
    wr(9'd511, 12'h055);
    check("b2b start no gap", {11'b0, tx}, 12'h000);
    rd(9'd510, 12'h000, "b2b no overrun");
    watch_tx(8'h55, 2, 39, "f3 tx");
    rd(9'd510, 12'h000, "f3 status edge 40");
    rd(9'd510, 12'h001, "f3 status edge 41");
    rd(9'd511, 12'h055, "last_char 55");

    // Reset mid-DATA: line returns high immediately and stays idle.
    wr(9'd511, 12'h03C);
    watch_tx(8'h3C, 1, 10, "f4 tx");
    rstn = 1'b0;
    #1;
    check("midframe reset tx", {11'b0, tx}, 12'h001);
    check("midframe reset data_out", data_out, 12'h000);
    step();
    rstn = 1'b1;
    rd(9'd510, 12'h001, "status after midframe reset");
    for (int k = 0; k < 45; k++) begin
      step();
      check($sformatf("no residual k=%0d", k), {11'b0, tx}, 12'h001);
    end

    // Decode: foreign address, sel, ignored status write.
    rd(9'd510, 12'h001, "status before foreign read");
    address     = 9'd12;
    read_enable = 1'b1;
    #1;
    check("sel addr 12", {11'b0, sel}, 12'h000);
    step();
    read_enable = 1'b0;
    check("foreign read", data_out, 12'h000);
    address = 9'd510;
    #1;
    check("sel addr 510", {11'b0, sel}, 12'h001);
    address = 9'd511;
    #1;
    check("sel addr 511", {11'b0, sel}, 12'h001);
    wr(9'd510, 12'h0FF);
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("status write no tx k=%0d", k), {11'b0, tx}, 12'h001);
    end
    rd(9'd510, 12'h001, "status after status write");
    rd(9'd511, 12'h000, "last_char after status write");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/simplez_tx_port.md
Name: simplez_tx_port

Overview:
- Memory-mapped serial output peripheral.
- Acts as the responder end of the Simplez main-memory bus (address, data, lec/esc strobes) and sits beside the memory on that bus.
- It answers CPU reads of a status word, accepts CPU writes of a character, and serializes the character as 8N1 on a TX line.
- This is the CPU's "screen" output device. The top level muxes its data_out with memory data_out using the sel output.

Parameters:
- STATUS_ADDR, 9'd510, bus address of the status register (read-only).
- DATA_ADDR, 9'd511, bus address of the data register (write: send char; read: last char written).
- BAUD_DIV, 104, clk cycles per serial bit (12 MHz / 115200). Must be >= 2.

Ports:
- clk  in  1  system clock; all registers act on the falling edge, same as the CPU core.
- rstn  in  1  reset; asynchronous, active-low.
- address  in  9  bus address (CPU RA).
- data_in  in  12  write data from CPU; only bits [7:0] are used.
- read_enable  in  1  CPU read strobe (lec).
- write_enable  in  1  CPU write strobe (esc).
- data_out  out  12  registered read data.
- sel  out  1  combinational: address equals STATUS_ADDR or DATA_ADDR.
- tx  out  1  serial line, idle high, registered.

Behaviour:
- Reset (asynchronous, rstn=0):
  - tx=1, data_out=0.
  - ready=1, overrun=0, last_char=0.
  - FSM=IDLE, baud and bit counters=0.
  - Asserting reset mid-frame aborts the frame immediately; tx returns high without waiting for a clock edge.
- Read, 1-edge latency, matching the memory. On a falling edge with read_enable=1:
  - address=STATUS_ADDR: data_out <= {10'b0, overrun, ready}. The same edge clears overrun.
  - address=DATA_ADDR: data_out <= {4'b0, last_char}.
  - Any other address: data_out <= 0.
  - With read_enable=0, data_out holds its value.
- Write: on a falling edge with write_enable=1 and address=DATA_ADDR:
  - If ready=1: last_char <= data_in[7:0]; shift register loaded; FSM -> START; tx <= 0; ready <= 0; baud counter <= 0.
  - If ready=0: write dropped, last_char unchanged, overrun <= 1.
  - Writes to STATUS_ADDR are ignored.
- Simultaneous read and write in the same edge: the read returns pre-edge state (old ready/last_char). If the write overruns while a status read clears overrun on that edge, set wins (overrun=1).
- FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - Each non-IDLE state lasts BAUD_DIV cycles, timed by the baud counter (counts 0..BAUD_DIV-1, then wraps and emits a bit_end pulse).
  - START: tx=0.
  - DATA: 8 bits sent LSB first; bit counter 0..7; shift right on each bit_end; DATA -> STOP after bit 7.
  - STOP: tx=1. At its bit_end: FSM -> IDLE, ready <= 1.
- Frame timing: ready reads 0 from the accept edge until exactly 10*BAUD_DIV edges later. A write accepted on the same edge that ready rises is legal.
- The baud counter runs only outside IDLE and restarts from 0 on each accepted write, so there is no phase carry-over between frames.

Decomposition:
- Shared package simplez_pkg holds:
  - the I/O address constants (STATUS_ADDR, DATA_ADDR);
  - the status bit indices (READY=0, OVERRUN=1);
  - the FSM state encoding (2 bits: IDLE, START, DATA, STOP).
- One natural sub-module: simplez_baud_tick. It is a counter with parameter BAUD_DIV, enable/restart inputs and a one-cycle bit_end output.
- Bus decode, registers and FSM stay in simplez_tx_port.

Test Plan:
- Reset then status read (BAUD_DIV=4): data_out=12'h001 one edge after lec, and tx=1.
- Write 12'h0A5 to 511: tx shows 0, 1,0,1,0,0,1,0,1, 1, each bit held 4 cycles. Status reads 12'h000 during the frame and 12'h001 exactly 40 edges after the accept edge.
- Second write 12'h041 mid-frame: frame continues unchanged. Status read returns 12'h002, and the next status read returns 12'h000 or 12'h001 (overrun cleared). Reading 511 returns 12'h0A5.
- Back-to-back: write 12'h055 on the same edge ready rises: accepted, no idle gap, overrun stays 0.
- rstn low for 1 cycle mid-DATA: tx=1 immediately. After release status=12'h001 and no residual bits appear on tx.
- Read of address 12 with lec=1: data_out=0 and sel=0. Address 510 gives sel=1 combinationally; write to 510 changes nothing.
